// File: rtl/uart_pkg.sv
// Shared constants for the UART command parser: state codes,
// default start-of-frame byte and error-bit positions.
package uart_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CMD     = 3'd1;
   localparam logic [2:0] ST_LEN     = 3'd2;
   localparam logic [2:0] ST_PAYLOAD = 3'd3;
   localparam logic [2:0] ST_CHK     = 3'd4;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

   localparam int ERR_TIMEOUT = 2;
   localparam int ERR_LEN     = 1;
   localparam int ERR_CHK     = 0;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// RX FIFO read handshake between a byte requester (master)
// and the UART receive FIFO (slave).
interface uart_cmd_parser_if;

   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_rd_en;

   modport master (
      output rx_rd_en,
      input  rx_valid,
      input  rx_data,
      input  rx_ready
   );

   modport slave (
      input  rx_rd_en,
      output rx_valid,
      output rx_data,
      output rx_ready
   );

endinterface

// File: rtl/uart_byte_fetch.sv
// Single-outstanding read engine for the RX FIFO; delivers one
// byte strobe per accepted i_rx_ready, can abandon a pending read.
module uart_byte_fetch
   import uart_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_drop,
   uart_cmd_parser_if.master   rx,
   output logic [7:0]          o_byte,
   output logic                o_byte_valid
);

   logic rd_en_q, rd_en_d;
   logic pend_q, pend_d;
   logic drop_q, drop_d;
   logic ready_hit;

   always_comb begin
      ready_hit = rx.rx_ready && pend_q;
      rd_en_d   = rx.rx_valid && !pend_q;
      pend_d    = pend_q;
      drop_d    = drop_q;
      if (rd_en_d) begin
         pend_d = 1'b1;
      end else if (ready_hit) begin
         pend_d = 1'b0;
      end
      // An abandoned read still has to be answered before the next one
      if (ready_hit) begin
         drop_d = 1'b0;
      end else if (i_drop && pend_q) begin
         drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en_q <= 1'b0;
         pend_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         rd_en_q <= rd_en_d;
         pend_q  <= pend_d;
         drop_q  <= drop_d;
      end
   end

   assign rx.rx_rd_en  = rd_en_q;
   assign o_byte       = rx.rx_data;
   assign o_byte_valid = ready_hit && !drop_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// Frame parser: SOF, CMD, LEN, payload, XOR checksum, with an
// inter-byte timeout and good-frame / error counters.
module uart_cmd_parser
   import uart_pkg::*;
#(
   parameter int         MAX_LEN     = 16,
   parameter logic [7:0] SOF         = SOF_DEFAULT,
   parameter int         TIMEOUT_CYC = 100_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_rx_valid,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_ready,
   output logic        o_rx_rd_en,
   output logic        o_pl_valid,
   output logic [7:0]  o_pl_data,
   output logic        o_pkt_valid,
   output logic [7:0]  o_cmd,
   output logic [7:0]  o_len,
   output logic [2:0]  o_err,
   output logic [15:0] o_pkt_cnt,
   output logic [7:0]  o_err_cnt,
   output logic [2:0]  t_state
);

   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]    MAXB = 8'(MAX_LEN);

   uart_cmd_parser_if fifo_if ();

   assign fifo_if.rx_valid = i_rx_valid;
   assign fifo_if.rx_data  = i_rx_data;
   assign fifo_if.rx_ready = i_rx_ready;
   assign o_rx_rd_en       = fifo_if.rx_rd_en;

   logic [7:0] byte_w;
   logic       byte_vld;
   logic       drop;

   uart_byte_fetch u_fetch (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_drop       (drop),
      .rx           (fifo_if.master),
      .o_byte       (byte_w),
      .o_byte_valid (byte_vld)
   );

   logic [2:0]    state_q, state_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    acc_q, acc_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          pl_valid_q, pl_valid_d;
   logic [7:0]    pl_data_q, pl_data_d;
   logic          pkt_valid_q, pkt_valid_d;
   logic [2:0]    err_q, err_d;
   logic [15:0]   pkt_cnt_q, pkt_cnt_d;
   logic [7:0]    err_cnt_q, err_cnt_d;

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      len_d       = len_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      timer_d     = timer_q;
      pl_valid_d  = 1'b0;
      pl_data_d   = pl_data_q;
      pkt_valid_d = 1'b0;
      err_d       = '0;
      drop        = 1'b0;

      // A byte arriving on the timeout cycle wins and clears the timer
      if (state_q == ST_IDLE || byte_vld) begin
         timer_d = '0;
      end else if (timer_q == TMAX) begin
         timer_d            = '0;
         err_d[ERR_TIMEOUT] = 1'b1;
         drop               = 1'b1;
         state_d            = ST_IDLE;
      end else begin
         timer_d = timer_q + 1'b1;
      end

      if (byte_vld) begin
         unique case (state_q)
            ST_IDLE: begin
               if (byte_w == SOF) state_d = ST_CMD;
            end
            ST_CMD: begin
               cmd_d   = byte_w;
               acc_d   = byte_w;
               state_d = ST_LEN;
            end
            ST_LEN: begin
               len_d = byte_w;
               acc_d = acc_q ^ byte_w;
               if (byte_w > MAXB) begin
                  err_d[ERR_LEN] = 1'b1;
                  state_d        = ST_IDLE;
               end else if (byte_w == 8'd0) begin
                  state_d = ST_CHK;
               end else begin
                  cnt_d   = byte_w;
                  state_d = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               acc_d      = acc_q ^ byte_w;
               pl_valid_d = 1'b1;
               pl_data_d  = byte_w;
               cnt_d      = cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_d = ST_CHK;
            end
            ST_CHK: begin
               if (byte_w == acc_q) begin
                  pkt_valid_d = 1'b1;
               end else begin
                  err_d[ERR_CHK] = 1'b1;
               end
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      pkt_cnt_d = pkt_cnt_q + {15'd0, pkt_valid_d};
      err_cnt_d = (err_d != 3'b000) ? sat_inc8(err_cnt_q) : err_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         len_q       <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         timer_q     <= '0;
         pl_valid_q  <= 1'b0;
         pl_data_q   <= '0;
         pkt_valid_q <= 1'b0;
         err_q       <= '0;
         pkt_cnt_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         timer_q     <= timer_d;
         pl_valid_q  <= pl_valid_d;
         pl_data_q   <= pl_data_d;
         pkt_valid_q <= pkt_valid_d;
         err_q       <= err_d;
         pkt_cnt_q   <= pkt_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign o_pl_valid  = pl_valid_q;
   assign o_pl_data   = pl_data_q;
   assign o_pkt_valid = pkt_valid_q;
   assign o_cmd       = cmd_q;
   assign o_len       = len_q;
   assign o_err       = err_q;
   assign o_pkt_cnt   = pkt_cnt_q;
   assign o_err_cnt   = err_cnt_q;
   assign t_state     = state_q;

endmodule
